// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan reader: glyph table and defaults.
// Segment patterns are active-low, ordered gfedcba (bit6=g ... bit0=a).
package seg7_pkg;

    localparam int DEF_NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Some drivers draw 9 without the bottom segment.
    localparam logic [6:0] SEG_NINE_ALT = 7'h18;

endpackage

// File: rtl/seg7_to_hex_m.sv
// Combinational glyph decoder: active-low segment pattern to nibble.
// o_legal is low for any pattern outside the glyph table.
module seg7_to_hex_m
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_legal,
    output logic [3:0] o_nib
);

    always_comb begin
        o_legal = 1'b0;
        o_nib   = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == SEG_CODE[i]) begin
                o_legal = 1'b1;
                o_nib   = 4'(i);
            end
        end
        if (i_seg == SEG_NINE_ALT) begin
            o_legal = 1'b1;
            o_nib   = 4'h9;
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reconstructs hex digits from a multiplexed active-low 7-segment bus.
// Pins are synchronised, qualified by stability, decoded and framed.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [6:0]              seg_i,
    input  logic [NUM_DIGITS-1:0]   an_i,
    output logic [4*NUM_DIGITS-1:0] hex_o,
    output logic [NUM_DIGITS-1:0]   dig_valid_o,
    output logic                    frame_o,
    output logic                    bad_o
);

    localparam int W  = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    localparam logic [W-1:0]  BUS_IDLE = {{NUM_DIGITS{1'b1}}, SEG_BLANK};
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_CAP  = CW'(STABLE_CYCLES - 1);

    logic [W-1:0]              r_s1;
    logic [W-1:0]              r_s2;
    logic [W-1:0]              r_prev;
    logic [CW-1:0]             r_cnt;
    logic [NUM_DIGITS-1:0]     r_seen;
    logic [4*NUM_DIGITS-1:0]   r_hex;
    logic [NUM_DIGITS-1:0]     r_valid;
    logic                      r_frame;
    logic                      r_bad;

    logic [NUM_DIGITS-1:0]     w_an_n;
    logic                      w_onehot;
    logic                      w_stable;
    logic                      w_cap;
    logic [NUM_DIGITS-1:0]     w_cap_mask;
    logic [NUM_DIGITS-1:0]     w_seen_next;
    logic                      w_frame;
    logic                      w_legal;
    logic [3:0]                w_nib;

    seg7_to_hex_m u_dec (
        .i_seg   (r_s2[6:0]),
        .o_legal (w_legal),
        .o_nib   (w_nib)
    );

    // Exactly one anode low: clear-lowest-set-bit leaves nothing.
    always_comb begin
        w_an_n      = ~r_s2[W-1:7];
        w_onehot    = (w_an_n != '0)
                   && ((w_an_n & (w_an_n - 1'b1)) == '0);
        w_stable    = (r_s2 == r_prev);
        w_cap       = w_stable && (r_cnt == CNT_CAP) && w_onehot;
        w_cap_mask  = w_cap ? w_an_n : '0;
        w_seen_next = r_seen | w_cap_mask;
        w_frame     = w_cap && (&w_seen_next);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1   <= BUS_IDLE;
            r_s2   <= BUS_IDLE;
            r_prev <= BUS_IDLE;
            r_cnt  <= '0;
        end else begin
            r_s1   <= {an_i, seg_i};
            r_s2   <= r_s1;
            r_prev <= r_s2;
            if (!w_stable)
                r_cnt <= '0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_seen  <= '0;
            r_hex   <= '0;
            r_valid <= '0;
            r_frame <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_frame <= w_frame;
            r_bad   <= w_cap && !w_legal;
            r_seen  <= w_frame ? '0 : w_seen_next;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (w_cap_mask[k]) begin
                    r_valid[k] <= w_legal;
                    if (w_legal)
                        r_hex[4*k +: 4] <= w_nib;
                end
            end
        end
    end

    assign hex_o       = r_hex;
    assign dig_valid_o = r_valid;
    assign frame_o     = r_frame;
    assign bad_o       = r_bad;

endmodule
